// File: rtl/bmem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one burst memory port, one line at a time.
// Optional: define BMEM_ARB_RADDR_CHECK_EN to drop returning beats whose address tag mismatches.
module bmem_arbiter #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BEAT_WIDTH  = 64,
   parameter bit          DCACHE_PRIO = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  i_addr,
   input  logic         i_read,
   output logic [255:0] i_rdata,
   output logic         i_resp,
   input  logic [31:0]  d_addr,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_rdata,
   output logic         d_resp,
   output logic [31:0]  bmem_addr,
   output logic         bmem_read,
   output logic         bmem_write,
   output logic [63:0]  bmem_wdata,
   input  logic         bmem_ready,
   input  logic [31:0]  bmem_raddr,
   input  logic [63:0]  bmem_rdata,
   input  logic         bmem_rvalid,
   output logic         raddr_err
);

   localparam int unsigned BEATS     = LINE_WIDTH / BEAT_WIDTH;
   localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWr, StDone} state_e;

   state_e         state_q, state_d;
   logic           grant_d_q, grant_d_d;    // 1: D-cache owns the transaction
   logic           last_d_q, last_d_d;      // 1: most recent grant went to the D-cache
   logic           write_q, write_d;
   logic [26:0]    addr_q, addr_d;
   logic [1:0]     beat_q, beat_d;
   logic [255:0]   line_q, line_d;
   logic [255:0]   i_rdata_q, i_rdata_d;
   logic [255:0]   d_rdata_q, d_rdata_d;
   logic           i_req, d_req, pick_d, beat_match;
   logic           err_q, err_d;

`ifdef BMEM_ARB_RADDR_CHECK_EN
   assign beat_match = (bmem_raddr[31:5] == addr_q);
   assign raddr_err  = err_q;
   logic unused_bits;
   assign unused_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr[4:0]};
`else
   assign beat_match = 1'b1;
   assign raddr_err  = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr, err_q};
`endif

   assign i_req = i_read;
   assign d_req = d_read | d_write;
   // On a tie the side that did not win last time goes first, unless D has fixed priority.
   assign pick_d = d_req & (~i_req | DCACHE_PRIO | ~last_d_q);

   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

   always_comb begin
      state_d    = state_q;
      grant_d_d  = grant_d_q;
      last_d_d   = last_d_q;
      write_d    = write_q;
      addr_d     = addr_q;
      beat_d     = beat_q;
      line_d     = line_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = err_q;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = 32'h0;
      bmem_wdata = 64'h0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_req || d_req) begin
               grant_d_d = pick_d;
               last_d_d  = pick_d;
               write_d   = pick_d & d_write;
               addr_d    = pick_d ? d_addr[31:5] : i_addr[31:5];
               beat_d    = 2'd0;
               state_d   = (pick_d && d_write) ? StWr : StRdReq;
            end
         end
         StRdReq: begin
            bmem_read = 1'b1;
            bmem_addr = {addr_q, 5'b0};
            if (bmem_ready) begin
               beat_d  = 2'd0;
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (bmem_rvalid) begin
               if (beat_match) begin
                  line_d[BEAT_WIDTH*beat_q +: BEAT_WIDTH] = bmem_rdata;
                  beat_d = beat_q + 2'd1;
                  if (beat_q == LAST_BEAT) begin
                     // Publish the line now so it is visible during the response cycle.
                     if (grant_d_q) d_rdata_d = line_d;
                     else           i_rdata_d = line_d;
                     state_d = StDone;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StWr: begin
            bmem_write = 1'b1;
            bmem_addr  = {addr_q, 5'b0};
            bmem_wdata = d_wdata[BEAT_WIDTH*beat_q +: BEAT_WIDTH];
            if (bmem_ready) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == LAST_BEAT) state_d = StDone;
            end
         end
         StDone: begin
            i_resp  = ~grant_d_q;
            d_resp  = grant_d_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_d_q <= 1'b0;
         last_d_q  <= 1'b1;
         write_q   <= 1'b0;
         addr_q    <= 27'h0;
         beat_q    <= 2'd0;
         line_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_d_q <= grant_d_d;
         last_d_q  <= last_d_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         beat_q    <= beat_d;
         line_q    <= line_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         err_q     <= err_d;
      end
   end

endmodule
